// File: rtl/mem_arbiter.sv
// Two-master (fetch / load-store) arbiter in front of a single-outstanding memory port.
// LSU has priority; a starvation counter forces an IF win after STARVE_LIMIT LSU wins.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_we,
  input  logic [3:0]  lsu_req_be,
  input  logic [31:0] lsu_req_wdata,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rsp_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [3:0]  mem_req_be,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        o_busy,
  output logic        o_owner
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        drop_q, drop_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        lsu_wins;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    starve_d      = starve_q;
    drop_d        = drop_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    if_req_ready  = 1'b0;
    lsu_req_ready = 1'b0;
    if_rsp_valid  = 1'b0;
    if_rsp_rdata  = '0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_rdata = '0;
    lsu_wins      = lsu_req_valid && !(if_req_valid && (starve_q == LIMIT));

    unique case (state_q)
      IDLE: begin
        if (lsu_wins) begin
          lsu_req_ready = 1'b1;
          owner_d       = 1'b1;
          addr_d        = lsu_req_addr;
          we_d          = lsu_req_we;
          be_d          = lsu_req_be;
          wdata_d       = lsu_req_wdata;
          drop_d        = 1'b0;
          state_d       = ISSUE;
          if (if_req_valid && (starve_q != LIMIT)) starve_d = starve_q + 4'd1;
        end else if (if_req_valid) begin
          if_req_ready = 1'b1;
          owner_d      = 1'b0;
          addr_d       = if_req_addr;
          we_d         = 1'b0;
          be_d         = 4'hF;
          wdata_d      = '0;
          drop_d       = 1'b0;
          starve_d     = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (!owner_q && i_flush) drop_d = 1'b1;
        if (mem_req_ready) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (!owner_q && i_flush) drop_d = 1'b1;
        if (mem_rsp_valid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (owner_q) begin
            lsu_rsp_valid = 1'b1;
            lsu_rsp_rdata = mem_rsp_rdata;
          end else if (!(drop_q || i_flush)) begin
            // A flush coinciding with the response still discards it.
            if_rsp_valid = 1'b1;
            if_rsp_rdata = mem_rsp_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    mem_req_valid = (state_q == ISSUE);
    o_busy        = (state_q != IDLE);
    o_owner       = owner_q;

    // Handshake/status outputs are forced low while reset is held, whatever the state.
    if (rst) begin
      if_req_ready  = 1'b0;
      lsu_req_ready = 1'b0;
      if_rsp_valid  = 1'b0;
      if_rsp_rdata  = '0;
      lsu_rsp_valid = 1'b0;
      lsu_rsp_rdata = '0;
      mem_req_valid = 1'b0;
      o_busy        = 1'b0;
      o_owner       = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      drop_q   <= 1'b0;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_be    = be_q;
  assign mem_req_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level priority/starvation model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        i_flush;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_rdata;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_we;
  logic [3:0]  lsu_req_be;
  logic [31:0] lsu_req_wdata;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [3:0]  mem_req_be;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        o_busy, o_owner;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_we(lsu_req_we), .lsu_req_be(lsu_req_be), .lsu_req_wdata(lsu_req_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .o_busy(o_busy), .o_owner(o_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int starve_m   = 0;  // model: consecutive LSU wins while IF waits

  typedef struct {
    logic        if_rdy, lsu_rdy, idle_busy, owner;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          issue_ok, wait_ok, no_spurious, no_rdy_outside;
    logic        if_rsp_v, lsu_rsp_v;
    logic [31:0] if_rdata, lsu_rdata;
  } obs_t;

  // Model: does LSU win an IDLE arbitration?
  function automatic logic model_lsu_wins(input logic iv, input logic lv);
    return lv && !(iv && (starve_m == LIMIT));
  endfunction

  task automatic model_update(input logic iv, input logic lsu_won);
    if (!lsu_won) starve_m = 0;
    else if (iv) starve_m = (starve_m + 1 > LIMIT) ? LIMIT : starve_m + 1;
  endtask

  // Drives one full transaction starting in IDLE and records what the DUT showed.
  // Flush bit c of fmask is applied in the c-th cycle after the grant.
  task automatic txn(input logic iv, input logic lv, input logic [31:0] ia, input logic [31:0] la,
                     input logic lwe, input logic [3:0] lbe, input logic [31:0] lwd,
                     input bit hold, input int bp, input int wt, input logic [15:0] fmask,
                     input logic [31:0] rsp_data, output obs_t o);
    int c;
    c = 0;
    o.issue_ok = 1; o.wait_ok = 1; o.no_spurious = 1; o.no_rdy_outside = 1;
    @(negedge clk);
    if_req_valid = iv; lsu_req_valid = lv;
    if_req_addr = ia; lsu_req_addr = la; lsu_req_we = lwe; lsu_req_be = lbe; lsu_req_wdata = lwd;
    mem_req_ready = 1'($urandom_range(0, 1));
    mem_rsp_valid = 1'($urandom_range(0, 1));
    mem_rsp_rdata = $urandom;
    i_flush = 1'($urandom_range(0, 1));
    #1;
    o.if_rdy = if_req_ready; o.lsu_rdy = lsu_req_ready; o.idle_busy = o_busy;
    if (if_rsp_valid || lsu_rsp_valid) o.no_spurious = 0;
    for (int k = 0; k <= bp; k++) begin
      @(negedge clk);
      if (!hold) begin if_req_valid = 1'b0; lsu_req_valid = 1'b0; end
      mem_req_ready = (k == bp);
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rsp_rdata = $urandom;
      i_flush = (c < 16) ? fmask[c] : 1'b0;
      c++;
      #1;
      if (k == 0) begin
        o.addr = mem_req_addr; o.we = mem_req_we; o.be = mem_req_be; o.wdata = mem_req_wdata;
        o.owner = o_owner;
      end else if ({mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata} !== {o.addr, o.we, o.be, o.wdata})
        o.issue_ok = 0;
      if (mem_req_valid !== 1'b1 || o_busy !== 1'b1) o.issue_ok = 0;
      if (if_rsp_valid || lsu_rsp_valid) o.no_spurious = 0;
      if (if_req_ready || lsu_req_ready) o.no_rdy_outside = 0;
    end
    for (int k = 0; k <= wt; k++) begin
      @(negedge clk);
      if (!hold) begin if_req_valid = 1'b0; lsu_req_valid = 1'b0; end
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = (k == wt);
      mem_rsp_rdata = (k == wt) ? rsp_data : $urandom;
      i_flush = (c < 16) ? fmask[c] : 1'b0;
      c++;
      #1;
      if (mem_req_valid !== 1'b0 || o_busy !== 1'b1) o.wait_ok = 0;
      if (if_req_ready || lsu_req_ready) o.no_rdy_outside = 0;
      if (k < wt) begin
        if (if_rsp_valid || lsu_rsp_valid || if_rsp_rdata != 0 || lsu_rsp_rdata != 0) o.wait_ok = 0;
      end else begin
        o.if_rsp_v = if_rsp_valid; o.lsu_rsp_v = lsu_rsp_valid;
        o.if_rdata = if_rsp_rdata; o.lsu_rdata = lsu_rsp_rdata;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b1; mem_rsp_rdata = $urandom; i_flush = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if ({if_req_ready, lsu_req_ready, mem_req_valid, if_rsp_valid, lsu_rsp_valid, o_busy, o_owner} !== 7'b0) begin
        miscompares++;
        $display("FAIL reset_outputs got %b required 0000000",
                 {if_req_ready, lsu_req_ready, mem_req_valid, if_rsp_valid, lsu_rsp_valid, o_busy, o_owner});
      end
    end
    @(negedge clk);
    rst = 1'b0; if_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b0; i_flush = 1'b0;
    #1;
    vectors++;
    if ({mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata, o_busy, o_owner} !== 71'b0) begin
      miscompares++;
      $display("FAIL reset_fields got addr=%h we=%b be=%h wdata=%h busy=%b owner=%b required all 0",
               mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata, o_busy, o_owner);
    end
    starve_m = 0;
  endtask

  task automatic test_if_read();
    obs_t o;
    txn(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 0, 0, 16'h0, 32'hDEADBEEF, o);
    model_update(1'b1, 1'b0);
    vectors++;
    if ({o.if_rdy, o.lsu_rdy, o.owner} !== 3'b100) begin
      miscompares++;
      $display("FAIL if_read_grant got if_rdy=%b lsu_rdy=%b owner=%b required 1 0 0", o.if_rdy, o.lsu_rdy, o.owner);
    end
    vectors++;
    if ({o.addr, o.we, o.be, o.wdata} !== {32'h100, 1'b0, 4'hF, 32'h0}) begin
      miscompares++;
      $display("FAIL if_read_fields got addr=%h we=%b be=%h wdata=%h required 100 0 f 0", o.addr, o.we, o.be, o.wdata);
    end
    vectors++;
    if ({o.if_rsp_v, o.lsu_rsp_v, o.if_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL if_read_rsp got if_v=%b lsu_v=%b data=%h required 1 0 deadbeef", o.if_rsp_v, o.lsu_rsp_v, o.if_rdata);
    end
    vectors++;
    if ({o.issue_ok, o.wait_ok, o.no_spurious} !== 3'b111) begin
      miscompares++;
      $display("FAIL if_read_protocol got issue=%b wait=%b clean=%b required 111", o.issue_ok, o.wait_ok, o.no_spurious);
    end
  endtask

  task automatic test_simultaneous();
    obs_t o1, o2;
    txn(1'b1, 1'b1, 32'hA0, 32'hB0, 1'b0, 4'hF, 32'h0, 1'b1, 0, 0, 16'h0, 32'h11, o1);
    model_update(1'b1, 1'b1);
    txn(1'b1, 1'b0, 32'hA0, 32'hB0, 1'b0, 4'hF, 32'h0, 1'b0, 0, 0, 16'h0, 32'h22, o2);
    model_update(1'b1, 1'b0);
    vectors++;
    if ({o1.lsu_rdy, o1.if_rdy, o1.owner, o1.addr} !== {3'b101, 32'hB0}) begin
      miscompares++;
      $display("FAIL simul_first got lsu_rdy=%b if_rdy=%b owner=%b addr=%h required 1 0 1 b0",
               o1.lsu_rdy, o1.if_rdy, o1.owner, o1.addr);
    end
    vectors++;
    if ({o2.lsu_rdy, o2.if_rdy, o2.owner, o2.addr, o2.if_rsp_v} !== {3'b010, 32'hA0, 1'b1}) begin
      miscompares++;
      $display("FAIL simul_second got lsu_rdy=%b if_rdy=%b owner=%b addr=%h if_v=%b required 0 1 0 a0 1",
               o2.lsu_rdy, o2.if_rdy, o2.owner, o2.addr, o2.if_rsp_v);
    end
    vectors++;
    if ({o1.no_rdy_outside, o1.lsu_rsp_v, o1.lsu_rdata} !== {2'b11, 32'h11}) begin
      miscompares++;
      $display("FAIL simul_lsu_rsp got no_rdy_out=%b lsu_v=%b data=%h required 1 1 11",
               o1.no_rdy_outside, o1.lsu_rsp_v, o1.lsu_rdata);
    end
  endtask

  task automatic test_lsu_store();
    obs_t o;
    int bp;
    bp = $urandom_range(0, 2);
    txn(1'b0, 1'b1, 32'h0, 32'h2000, 1'b1, 4'b0011, 32'h1234, 1'b0, bp, 1, 16'h0, $urandom, o);
    model_update(1'b0, 1'b1);
    vectors++;
    if ({o.addr, o.we, o.be, o.wdata} !== {32'h2000, 1'b1, 4'b0011, 32'h1234}) begin
      miscompares++;
      $display("FAIL store_fields got addr=%h we=%b be=%b wdata=%h required 2000 1 0011 1234", o.addr, o.we, o.be, o.wdata);
    end
    vectors++;
    if ({o.lsu_rsp_v, o.if_rsp_v, o.issue_ok, o.wait_ok} !== 4'b1011) begin
      miscompares++;
      $display("FAIL store_ack got lsu_v=%b if_v=%b issue=%b wait=%b required 1 0 1 1", o.lsu_rsp_v, o.if_rsp_v, o.issue_ok, o.wait_ok);
    end
  endtask

  task automatic test_starvation();
    obs_t o;
    logic [9:0] order;
    bit rdy_ok;
    rdy_ok = 1;
    for (int n = 0; n < 10; n++) begin
      txn(1'b1, 1'b1, 32'hC00 + n, 32'hD00 + n, 1'b0, 4'hF, 32'h0, 1'b1, 0, 0, 16'h0, $urandom, o);
      order[9 - n] = o.owner;
      if (o.if_rdy === o.lsu_rdy || o.lsu_rdy !== o.owner || !o.no_rdy_outside) rdy_ok = 0;
      model_update(1'b1, o.owner);
    end
    vectors++;
    if (order !== 10'b1111011110) begin
      miscompares++;
      $display("FAIL starve_order got %b required 1111011110 (1=LSU)", order);
    end
    vectors++;
    if (!rdy_ok) begin
      miscompares++;
      $display("FAIL starve_ready got inconsistent ready/owner required one-hot ready matching owner");
    end
  endtask

  task automatic test_flush();
    obs_t o;
    txn(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1, 2, 16'b0000_0100, 32'hCAFE0001, o);
    model_update(1'b1, 1'b0);
    vectors++;
    if ({o.if_rsp_v, o.if_rdata, o.issue_ok, o.wait_ok} !== {1'b0, 32'h0, 2'b11}) begin
      miscompares++;
      $display("FAIL flush_drop got if_v=%b data=%h issue=%b wait=%b required 0 0 1 1", o.if_rsp_v, o.if_rdata, o.issue_ok, o.wait_ok);
    end
    txn(1'b1, 1'b0, 32'h304, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 0, 1, 16'h0, 32'hCAFE0002, o);
    model_update(1'b1, 1'b0);
    vectors++;
    if ({o.if_rdy, o.addr, o.if_rsp_v, o.if_rdata} !== {1'b1, 32'h304, 1'b1, 32'hCAFE0002}) begin
      miscompares++;
      $display("FAIL flush_next got rdy=%b addr=%h if_v=%b data=%h required 1 304 1 cafe0002", o.if_rdy, o.addr, o.if_rsp_v, o.if_rdata);
    end
    txn(1'b0, 1'b1, 32'h0, 32'h400, 1'b0, 4'hF, 32'h0, 1'b0, 1, 1, 16'hFFFF, 32'hCAFE0003, o);
    model_update(1'b0, 1'b1);
    vectors++;
    if ({o.lsu_rsp_v, o.lsu_rdata} !== {1'b1, 32'hCAFE0003}) begin
      miscompares++;
      $display("FAIL flush_lsu got lsu_v=%b data=%h required 1 cafe0003", o.lsu_rsp_v, o.lsu_rdata);
    end
  endtask

  task automatic test_backpressure_reset();
    obs_t o;
    txn(1'b0, 1'b1, 32'h0, 32'h5000, 1'b1, 4'hC, 32'hA5A5, 1'b0, 5, 0, 16'h0, $urandom, o);
    model_update(1'b0, 1'b1);
    vectors++;
    if ({o.issue_ok, o.addr, o.we, o.be, o.wdata} !== {1'b1, 32'h5000, 1'b1, 4'hC, 32'hA5A5}) begin
      miscompares++;
      $display("FAIL bp_stable got stable=%b addr=%h we=%b be=%h wdata=%h required 1 5000 1 c a5a5",
               o.issue_ok, o.addr, o.we, o.be, o.wdata);
    end
    // Cycle 1 grant, cycle 2 issue stalled, cycle 3 reset.
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h600; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; i_flush = 1'b0;
    @(negedge clk);
    if_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; if_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_req_ready = 1'b1;
    #1;
    vectors++;
    if ({if_req_ready, lsu_req_ready, mem_req_valid, if_rsp_valid, lsu_rsp_valid, o_busy, o_owner} !== 7'b0) begin
      miscompares++;
      $display("FAIL mid_reset got %b required 0000000",
               {if_req_ready, lsu_req_ready, mem_req_valid, if_rsp_valid, lsu_rsp_valid, o_busy, o_owner});
    end
    @(negedge clk);
    rst = 1'b0; if_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBAD0BAD0;
    starve_m = 0;
    #1;
    vectors++;
    if ({if_rsp_valid, lsu_rsp_valid, if_rsp_rdata, mem_req_valid, o_busy, o_owner} !== 37'b0) begin
      miscompares++;
      $display("FAIL late_rsp got if_v=%b lsu_v=%b data=%h mem_v=%b busy=%b owner=%b required all 0",
               if_rsp_valid, lsu_rsp_valid, if_rsp_rdata, mem_req_valid, o_busy, o_owner);
    end
    txn(1'b1, 1'b0, 32'h700, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 0, 0, 16'h0, 32'h7777, o);
    model_update(1'b1, 1'b0);
    vectors++;
    if ({o.addr, o.if_rsp_v, o.if_rdata} !== {32'h700, 1'b1, 32'h7777}) begin
      miscompares++;
      $display("FAIL post_reset got addr=%h if_v=%b data=%h required 700 1 7777", o.addr, o.if_rsp_v, o.if_rdata);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic iv, lv, lwin, lwe, drop, exp_if_v;
    logic [31:0] ia, la, lwd, rsp;
    logic [3:0] lbe;
    logic [15:0] fmask;
    bit hold;
    int bp, wt, n;
    for (int t = 0; t < 40; t++) begin
      iv = 1'($urandom_range(0, 1)); lv = 1'($urandom_range(0, 1));
      if (!iv && !lv) lv = 1'b1;
      ia = $urandom; la = $urandom; lwd = $urandom; rsp = $urandom;
      lwe = 1'($urandom_range(0, 1)); lbe = 4'($urandom_range(0, 15));
      hold = 1'($urandom_range(0, 1));
      bp = $urandom_range(0, 3); wt = $urandom_range(0, 3); n = bp + wt + 2;
      fmask = ($urandom_range(0, 2) == 0) ? (16'd1 << $urandom_range(0, n - 2)) : 16'd0;
      lwin = model_lsu_wins(iv, lv);
      txn(iv, lv, ia, la, lwe, lbe, lwd, hold, bp, wt, fmask, rsp, o);
      model_update(iv, lwin);
      drop = !lwin && (fmask != 0);
      exp_if_v = !lwin && !drop;
      vectors++;
      if ({o.if_rdy, o.lsu_rdy, o.owner} !== {!lwin, lwin, lwin}) begin
        miscompares++;
        $display("FAIL rnd%0d_grant got if_rdy=%b lsu_rdy=%b owner=%b required %b %b %b",
                 t, o.if_rdy, o.lsu_rdy, o.owner, !lwin, lwin, lwin);
      end
      vectors++;
      if ({o.addr, o.we, o.be, o.wdata} !== (lwin ? {la, lwe, lbe, lwd} : {ia, 1'b0, 4'hF, 32'h0})) begin
        miscompares++;
        $display("FAIL rnd%0d_fields got addr=%h we=%b be=%h wdata=%h (lsu_win=%b)", t, o.addr, o.we, o.be, o.wdata, lwin);
      end
      vectors++;
      if ({o.if_rsp_v, o.lsu_rsp_v, o.if_rdata} !== {exp_if_v, lwin, (exp_if_v ? rsp : 32'h0)}) begin
        miscompares++;
        $display("FAIL rnd%0d_rsp got if_v=%b lsu_v=%b if_data=%h required %b %b %h",
                 t, o.if_rsp_v, o.lsu_rsp_v, o.if_rdata, exp_if_v, lwin, (exp_if_v ? rsp : 32'h0));
      end
      if (lwin && !lwe) begin
        vectors++;
        if (o.lsu_rdata !== rsp) begin
          miscompares++;
          $display("FAIL rnd%0d_lsu_data got %h required %h", t, o.lsu_rdata, rsp);
        end
      end
      vectors++;
      if ({o.issue_ok, o.wait_ok, o.no_spurious, o.no_rdy_outside, o.idle_busy} !== 5'b11110) begin
        miscompares++;
        $display("FAIL rnd%0d_protocol got issue=%b wait=%b clean=%b no_rdy=%b idle_busy=%b required 1 1 1 1 0",
                 t, o.issue_ok, o.wait_ok, o.no_spurious, o.no_rdy_outside, o.idle_busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1; i_flush = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_we = 1'b0; lsu_req_be = '0; lsu_req_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    test_reset();
    test_if_read();
    test_simultaneous();
    test_lsu_store();
    test_starvation();
    test_flush();
    test_backpressure_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the number of consecutive LSU wins after which a waiting IF request is forced to win; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 i_flush  input  1  SHALL be the fetch flush; discards any IF response still outstanding.
REQ-005 if_req_valid/if_req_ready  input/output  1/1  SHALL be the fetch request handshake.
REQ-006 if_req_addr  input  32  SHALL be the fetch word address.
REQ-007 if_rsp_valid/if_rsp_rdata  output  1/32  SHALL be the fetch response pulse and data.
REQ-008 lsu_req_valid/lsu_req_ready  input/output  1/1  SHALL be the load/store request handshake.
REQ-009 lsu_req_addr, lsu_req_we, lsu_req_be, lsu_req_wdata  input  32/1/4/32  SHALL be the load/store address, write enable, byte enables and write data.
REQ-010 lsu_rsp_valid/lsu_rsp_rdata  output  1/32  SHALL be the load/store response pulse and data.
REQ-011 mem_req_valid/mem_req_ready  output/input  1/1  SHALL be the shared memory request handshake.
REQ-012 mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata  output  32/1/4/32  SHALL be the shared memory request fields.
REQ-013 mem_rsp_valid/mem_rsp_rdata  input  1/32  SHALL be the shared memory response.
REQ-014 o_busy/o_owner  output  1/1  SHALL give transaction-in-flight status and the current owner (0=IF, 1=LSU).

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT_RSP; only one memory transaction is outstanding at a time.
REQ-016 In IDLE with only one valid requester, that requester SHALL win; with both valid, LSU SHALL win unless starve_cnt == STARVE_LIMIT, in which case IF wins.
REQ-017 The winner's req_ready SHALL be high combinationally in that IDLE cycle; the loser's ready and all ready outputs outside IDLE SHALL be low.
REQ-018 On grant, the arbiter SHALL latch addr/we/be/wdata and the owner, then move to ISSUE.
REQ-019 For IF grants, the latched values SHALL be we=0 and be=4'hF; wdata SHALL be 0.
REQ-020 In ISSUE, mem_req_valid SHALL be 1 with latched fields held stable until mem_req_ready=1, then the FSM moves to WAIT_RSP; there is no timeout.
REQ-021 In WAIT_RSP, on mem_rsp_valid=1 the owner's rsp_valid SHALL pulse for exactly that cycle, rsp_rdata SHALL equal mem_rsp_rdata, and the FSM returns to IDLE.
REQ-022 Writes SHALL also receive an lsu_rsp_valid acknowledge; the data is don't-care.
REQ-023 mem_rsp_valid in IDLE or ISSUE SHALL be ignored.
REQ-024 The minimum cost is 3 cycles per transaction: grant, issue and response.
REQ-025 starve_cnt (4 bits) SHALL increment, saturating at STARVE_LIMIT, on each LSU grant made while if_req_valid=1, and clear to 0 on any IF grant.
REQ-026 If i_flush=1 in any cycle while owner=IF and state is ISSUE or WAIT_RSP, the arbiter SHALL set a drop flag; the memory transaction completes normally but if_rsp_valid is suppressed.
REQ-027 The drop flag SHALL clear on return to IDLE.
REQ-028 i_flush in IDLE or with owner=LSU SHALL have no effect.
REQ-029 o_busy SHALL be 1 in ISSUE and WAIT_RSP; o_owner SHALL hold the last granted owner.
REQ-030 Response outputs SHALL be combinational from mem_rsp_* gated by state and owner; rsp_rdata SHALL be 0 when rsp_valid=0.

Reset
REQ-031 While rst=1 at a clock edge, the arbiter SHALL set state=IDLE, starve_cnt=0, drop flag=0, owner=0 and all latched fields=0.
REQ-032 During reset all ready/valid outputs, o_busy and o_owner SHALL be 0, regardless of inputs.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction; a late mem_rsp_valid after reset SHALL be ignored.

Verification
REQ-034 IF-only read: if_req_addr=0x100 with mem_req_ready=1 and a response 0xDEADBEEF one cycle after acceptance SHALL give mem_req_addr=0x100, we=0, be=F and if_rsp_valid for 1 cycle carrying 0xDEADBEEF.
REQ-035 Simultaneous requests: IF and LSU valid in the same cycle SHALL grant LSU first and IF second.
REQ-036 LSU store: addr 0x2000, be=4'b0011, wdata 0x1234 SHALL appear on the mem port unchanged and return an lsu_rsp_valid acknowledge.
REQ-037 Starvation: with STARVE_LIMIT=4, IF and LSU held valid continuously SHALL give the grant order L,L,L,L,I,L,L,L,L,I.
REQ-038 Flush: i_flush pulsed during WAIT_RSP of an IF read SHALL still complete the mem handshake, give no if_rsp_valid and leave the next IF grant unaffected.
REQ-039 Backpressure and reset: mem_req_ready held low for 5 cycles SHALL keep the fields stable; rst=1 in cycle 3 SHALL return IDLE, all outputs 0 and a later mem_rsp_valid ignored.
